// File: rtl/posit_defines_pkg.sv
// Shared posit decode definitions: field-width helpers, decode type and framing states.
package posit_defines;

  typedef enum logic {NORMAL} pd_type_e;

  typedef enum logic {FR_IDLE, FR_IN_WIN} frame_state_e;

  // Top POSIT_WIDTH bits of this pattern give the NaR word for any width up to 64.
  localparam logic [63:0] NAR_PATTERN = 64'h8000_0000_0000_0000;

  function automatic int unsigned get_scale_width(pd_type_e t, int unsigned w, int unsigned es);
    int unsigned span;
    span = (w - 1) << es;
    return (t == NORMAL) ? ($clog2(span) + 1) : ($clog2(span) + 1);
  endfunction

  function automatic int unsigned get_fraction_width(pd_type_e t, int unsigned w, int unsigned es);
    return (t == NORMAL) ? (w - 3 - es) : (w - 3 - es);
  endfunction

endpackage

// File: rtl/pd_control_if.sv
// Denormalized posit result channel (rts/rtr handshake with window framing).
interface pd_control_if #(
  parameter int unsigned SCALE_WIDTH    = 4,
  parameter int unsigned FRACTION_WIDTH = 5
) ();
  logic                             rts;
  logic                             rtr;
  logic                             sow;
  logic                             eow;
  logic                             sign;
  logic                             zero;
  logic                             nar;
  logic signed [SCALE_WIDTH-1:0]    scale;
  logic        [FRACTION_WIDTH-1:0] fraction;
  logic                             guard;
  logic                             round;
  logic                             sticky;

  modport master (output rts, sow, eow, sign, zero, nar, scale, fraction, guard, round, sticky,
                  input  rtr);
  modport slave  (input  rts, sow, eow, sign, zero, nar, scale, fraction, guard, round, sticky,
                  output rtr);
endinterface

// File: rtl/posit_regime_decode.sv
// Combinational posit body decode: regime run -> k, exponent bits e, MSB-aligned fraction.
module posit_regime_decode #(
  parameter int unsigned POSIT_WIDTH = 8,
  parameter int unsigned POSIT_ES    = 0,
  parameter int unsigned K_WIDTH     = 4,
  parameter int unsigned FRAC_WIDTH  = 5,
  parameter int unsigned E_WIDTH     = 1
) (
  input  logic        [POSIT_WIDTH-2:0] body_i,
  output logic signed [K_WIDTH-1:0]     k_o,
  output logic        [E_WIDTH-1:0]     e_o,
  output logic        [FRAC_WIDTH-1:0]  frac_o
);
  localparam int unsigned BW = POSIT_WIDTH - 1;

  logic [BW-1:0] sh;
  logic [BW-1:0] rem;
  logic          rb;
  logic          done;
  int unsigned   run;
  int            kint;

  always_comb begin
    rb   = body_i[BW-1];
    sh   = body_i;
    run  = 0;
    done = 1'b0;
    for (int unsigned i = 0; i < BW; i++) begin
      if (!done && (sh[BW-1] == rb)) run = run + 1;
      else                           done = 1'b1;
      sh = sh << 1;
    end
    kint = rb ? (int'(run) - 1) : -int'(run);
    k_o  = K_WIDTH'(kint);
    // Drop regime run plus terminator; exponent then fraction sit at the top of rem.
    rem    = body_i << (run + 1);
    e_o    = E_WIDTH'(rem >> (BW - POSIT_ES));
    frac_o = FRAC_WIDTH'(rem >> (BW - POSIT_ES - FRAC_WIDTH));
  end

endmodule

// File: rtl/posit_stream_denormalize.sv
// Stream posit decoder: skid latch, 2-stage decode pipeline, window-framing checks.
module posit_stream_denormalize
  import posit_defines::*;
#(
  parameter int unsigned POSIT_WIDTH = 8,
  parameter int unsigned POSIT_ES    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rts_i,
  input  logic                   sow_i,
  input  logic                   eow_i,
  input  logic [POSIT_WIDTH-1:0] data_i,
  output logic                   rtr_o,
  pd_control_if.master           result,
  output logic [15:0]            win_cnt_o,
  output logic                   proto_err_o
);
  localparam int unsigned SCALE_W = get_scale_width(NORMAL, POSIT_WIDTH, POSIT_ES);
  localparam int unsigned FRAC_W  = get_fraction_width(NORMAL, POSIT_WIDTH, POSIT_ES);
  localparam int unsigned E_W     = (POSIT_ES > 0) ? POSIT_ES : 1;
  localparam logic [POSIT_WIDTH-1:0] NAR_WORD = NAR_PATTERN[63 -: POSIT_WIDTH];

  logic process_en, receive_en, s1_en;
  logic rtr_q, rtr_d;
  logic skid_vld_q, skid_vld_d, skid_sow_q, skid_sow_d, skid_eow_q, skid_eow_d;
  logic [POSIT_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [POSIT_WIDTH-1:0] in_data;
  logic in_sow, in_eow;
  logic s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d;
  logic s1_nar_q, s1_nar_d, s1_sow_q, s1_sow_d, s1_eow_q, s1_eow_d;
  logic [POSIT_WIDTH-2:0] s1_abs_q, s1_abs_d;
  logic rts_q, rts_d, sow_q, sow_d, eow_q, eow_d;
  logic sign_q, sign_d, zero_q, zero_d, nar_q, nar_d;
  logic signed [SCALE_W-1:0] scale_q, scale_d, scale_calc;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic signed [SCALE_W-1:0] dec_k;
  logic [E_W-1:0]            dec_e;
  logic [FRAC_W-1:0]         dec_frac;
  frame_state_e state_q, state_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic err_q, err_d;

  assign process_en = result.rtr | ~rts_q;
  assign receive_en = rts_i & rtr_q;
  assign s1_en      = process_en & (receive_en | skid_vld_q);

  posit_regime_decode #(
    .POSIT_WIDTH(POSIT_WIDTH), .POSIT_ES(POSIT_ES), .K_WIDTH(SCALE_W),
    .FRAC_WIDTH(FRAC_W), .E_WIDTH(E_W)
  ) u_regime (
    .body_i(s1_abs_q), .k_o(dec_k), .e_o(dec_e), .frac_o(dec_frac)
  );

  assign scale_calc = (dec_k <<< POSIT_ES) + SCALE_W'(dec_e);

  always_comb begin
    rtr_d       = process_en;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_sow_d  = skid_sow_q;
    skid_eow_d  = skid_eow_q;
    if (process_en) begin
      skid_vld_d = 1'b0;
    end else if (receive_en) begin
      skid_vld_d  = 1'b1;
      skid_data_d = data_i;
      skid_sow_d  = sow_i;
      skid_eow_d  = eow_i;
    end

    in_data = skid_vld_q ? skid_data_q : data_i;
    in_sow  = skid_vld_q ? skid_sow_q  : sow_i;
    in_eow  = skid_vld_q ? skid_eow_q  : eow_i;

    s1_vld_d  = s1_vld_q;
    s1_sign_d = s1_sign_q;
    s1_zero_d = s1_zero_q;
    s1_nar_d  = s1_nar_q;
    s1_abs_d  = s1_abs_q;
    s1_sow_d  = s1_sow_q;
    s1_eow_d  = s1_eow_q;
    if (s1_en) begin
      s1_vld_d  = 1'b1;
      s1_sign_d = in_data[POSIT_WIDTH-1];
      s1_zero_d = (in_data == '0);
      s1_nar_d  = (in_data == NAR_WORD);
      s1_abs_d  = (POSIT_WIDTH-1)'(in_data[POSIT_WIDTH-1] ? -in_data : in_data);
      s1_sow_d  = in_sow;
      s1_eow_d  = in_eow;
    end else if (process_en) begin
      s1_vld_d = 1'b0;
    end

    rts_d   = rts_q;
    sow_d   = sow_q;
    eow_d   = eow_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    nar_d   = nar_q;
    scale_d = scale_q;
    frac_d  = frac_q;
    if (process_en) begin
      rts_d   = s1_vld_q;
      sow_d   = s1_sow_q;
      eow_d   = s1_eow_q;
      sign_d  = s1_sign_q;
      zero_d  = s1_zero_q;
      nar_d   = s1_nar_q;
      scale_d = (s1_zero_q | s1_nar_q) ? '0 : scale_calc;
      frac_d  = (s1_zero_q | s1_nar_q) ? '0 : dec_frac;
    end
  end

  // Framing is tracked at the accept point, independent of downstream stalls.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    err_d     = err_q;
    if (receive_en) begin
      if (sow_i) begin
        if (state_q == FR_IN_WIN) err_d = 1'b1;
        win_cnt_d = 16'd1;
        state_d   = eow_i ? FR_IDLE : FR_IN_WIN;
      end else if (state_q == FR_IDLE) begin
        err_d = 1'b1;
      end else begin
        if (win_cnt_q != '1) win_cnt_d = win_cnt_q + 16'd1;
        if (eow_i) state_d = FR_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rtr_q       <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sow_q  <= 1'b0;
      skid_eow_q  <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      s1_abs_q    <= '0;
      s1_sow_q    <= 1'b0;
      s1_eow_q    <= 1'b0;
      rts_q       <= 1'b0;
      sow_q       <= 1'b0;
      eow_q       <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      nar_q       <= 1'b0;
      scale_q     <= '0;
      frac_q      <= '0;
      state_q     <= FR_IDLE;
      win_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rtr_q       <= rtr_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_sow_q  <= skid_sow_d;
      skid_eow_q  <= skid_eow_d;
      s1_vld_q    <= s1_vld_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_nar_q    <= s1_nar_d;
      s1_abs_q    <= s1_abs_d;
      s1_sow_q    <= s1_sow_d;
      s1_eow_q    <= s1_eow_d;
      rts_q       <= rts_d;
      sow_q       <= sow_d;
      eow_q       <= eow_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      nar_q       <= nar_d;
      scale_q     <= scale_d;
      frac_q      <= frac_d;
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      err_q       <= err_d;
    end
  end

  assign rtr_o           = rtr_q;
  assign result.rts      = rts_q;
  assign result.sow      = sow_q;
  assign result.eow      = eow_q;
  assign result.sign     = sign_q;
  assign result.zero     = zero_q;
  assign result.nar      = nar_q;
  assign result.scale    = scale_q;
  assign result.fraction = frac_q;
  assign result.guard    = 1'b0;
  assign result.round    = 1'b0;
  assign result.sticky   = 1'b0;
  assign win_cnt_o       = win_cnt_q;
  assign proto_err_o     = err_q;

endmodule

// File: tb/tb_posit_stream_denormalize.sv
// Directed bench for posit_stream_denormalize at POSIT_WIDTH=8, ES=0 (scale 4b, fraction 5b).
module tb_posit_stream_denormalize;
  localparam int unsigned W  = 8;
  localparam int unsigned ES = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rts_i = 1'b0;
  logic        sow_i = 1'b0;
  logic        eow_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        rtr_o;
  logic [15:0] win_cnt_o;
  logic        proto_err_o;

  pd_control_if #(.SCALE_WIDTH(4), .FRACTION_WIDTH(5)) res_if ();

  int checks = 0;
  int failures = 0;
  logic [13:0] outq[$];

  posit_stream_denormalize #(.POSIT_WIDTH(W), .POSIT_ES(ES)) dut (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .sow_i(sow_i), .eow_i(eow_i),
    .data_i(data_i), .rtr_o(rtr_o), .result(res_if), .win_cnt_o(win_cnt_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  // Record each result word transferred at the following rising edge.
  always @(negedge clk) begin
    if (res_if.rts && res_if.rtr)
      outq.push_back({res_if.sow, res_if.eow, res_if.sign, res_if.zero, res_if.nar,
                      res_if.scale, res_if.fraction});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] mk(logic so, logic eo, logic sg, logic z, logic n,
                                     logic [3:0] sc, logic [4:0] fr);
    return {so, eo, sg, z, n, sc, fr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic s, input logic e);
    int unsigned n = 0;
    rts_i = 1'b1; data_i = d; sow_i = s; eow_i = e;
    while (!rtr_o && n < 50) begin tick(); n++; end
    if (!rtr_o) begin
      checks++; failures++;
      $display("FAIL send_timeout rtr_o=%b required=1", rtr_o);
    end
    tick();
    rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0;
  endtask

  task automatic wait_q(input int unsigned n);
    int unsigned c = 0;
    while (outq.size() < n && c < 100) begin tick(); c++; end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rts_i = 1'b0; res_if.rtr = 1'b1;
    tick(); tick();
    checks++; if (rtr_o !== 1'b0) begin failures++; $display("FAIL reset_rtr got=%b exp=0", rtr_o); end
    checks++; if (res_if.rts !== 1'b0) begin failures++; $display("FAIL reset_rts got=%b exp=0", res_if.rts); end
    checks++; if (win_cnt_o !== 16'd0 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL reset_frame cnt=%h err=%b exp=0/0", win_cnt_o, proto_err_o); end
    checks++; if ({res_if.sow, res_if.eow, res_if.sign, res_if.zero, res_if.nar, res_if.scale,
                   res_if.fraction} !== 14'd0) begin
      failures++; $display("FAIL reset_fields got nonzero exp=0"); end
    rst_n = 1'b1;
    tick();
    checks++; if (rtr_o !== 1'b1) begin failures++; $display("FAIL reset_release_rtr got=%b exp=1", rtr_o); end
    outq.delete();
  endtask

  task automatic test_single_word();
    logic [13:0] got;
    outq.delete();
    rts_i = 1'b1; data_i = 8'h40; sow_i = 1'b1; eow_i = 1'b1;
    tick();
    rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0;
    checks++; if (res_if.rts !== 1'b0) begin failures++; $display("FAIL single_early_rts got=%b exp=0", res_if.rts); end
    checks++; if (win_cnt_o !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", win_cnt_o); end
    tick();
    checks++; if (res_if.rts !== 1'b1) begin failures++; $display("FAIL single_rts got=%b exp=1", res_if.rts); end
    got = {res_if.sow, res_if.eow, res_if.sign, res_if.zero, res_if.nar, res_if.scale, res_if.fraction};
    checks++; if (got !== mk(1, 1, 0, 0, 0, 4'd0, 5'b00000)) begin
      failures++; $display("FAIL single_fields got=%h exp=%h", got, mk(1, 1, 0, 0, 0, 4'd0, 5'b00000)); end
    checks++; if ({res_if.guard, res_if.round, res_if.sticky} !== 3'b000 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL single_grs_err grs=%b%b%b err=%b exp=000/0",
                           res_if.guard, res_if.round, res_if.sticky, proto_err_o); end
    wait_q(1);
  endtask

  task automatic test_decode_stream();
    logic [7:0]  w[4]   = '{8'h50, 8'h60, 8'h01, 8'h7F};
    logic [13:0] ex[4]  = '{mk(1, 0, 0, 0, 0, 4'd0, 5'b10000), mk(0, 0, 0, 0, 0, 4'd1, 5'b00000),
                            mk(0, 0, 0, 0, 0, 4'hA, 5'b00000), mk(0, 1, 0, 0, 0, 4'd6, 5'b00000)};
    outq.delete();
    for (int i = 0; i < 4; i++) send_word(w[i], i == 0, i == 3);
    wait_q(4);
    checks++; if (outq.size() != 4) begin failures++; $display("FAIL stream_count got=%0d exp=4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      checks++; if (outq[i] !== ex[i]) begin failures++; $display("FAIL stream_word%0d got=%h exp=%h", i, outq[i], ex[i]); end
    end
    checks++; if (win_cnt_o !== 16'd4 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL stream_frame cnt=%0d err=%b exp=4/0", win_cnt_o, proto_err_o); end
  endtask

  task automatic test_sign_special();
    logic [7:0]  w[4]  = '{8'hC0, 8'h00, 8'h80, 8'hB0};
    logic [13:0] ex[4] = '{mk(1, 1, 1, 0, 0, 4'd0, 5'b00000), mk(1, 1, 0, 1, 0, 4'd0, 5'b00000),
                           mk(1, 1, 1, 0, 1, 4'd0, 5'b00000), mk(1, 1, 1, 0, 0, 4'd0, 5'b10000)};
    outq.delete();
    for (int i = 0; i < 4; i++) send_word(w[i], 1'b1, 1'b1);
    wait_q(4);
    checks++; if (outq.size() != 4) begin failures++; $display("FAIL special_count got=%0d exp=4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      checks++; if (outq[i] !== ex[i]) begin failures++; $display("FAIL special_word%0d got=%h exp=%h", i, outq[i], ex[i]); end
    end
    checks++; if (win_cnt_o !== 16'd1 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL special_frame cnt=%0d err=%b exp=1/0", win_cnt_o, proto_err_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  w[6]  = '{8'h40, 8'h50, 8'h60, 8'h01, 8'h7F, 8'h48};
    logic [13:0] ex[6] = '{mk(1, 0, 0, 0, 0, 4'd0, 5'b00000), mk(0, 0, 0, 0, 0, 4'd0, 5'b10000),
                           mk(0, 0, 0, 0, 0, 4'd1, 5'b00000), mk(0, 0, 0, 0, 0, 4'hA, 5'b00000),
                           mk(0, 0, 0, 0, 0, 4'd6, 5'b00000), mk(0, 1, 0, 0, 0, 4'd0, 5'b01000)};
    int  idx = 0;
    logic acc;
    outq.delete();
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      res_if.rtr = !(cyc >= 3 && cyc < 6);
      rts_i = 1'b1; data_i = w[idx]; sow_i = (idx == 0); eow_i = (idx == 5);
      if (cyc == 3) begin
        checks++; if (rtr_o !== 1'b1) begin failures++; $display("FAIL bp_rtr_before got=%b exp=1", rtr_o); end
      end
      if (cyc == 4) begin
        checks++; if (rtr_o !== 1'b0) begin failures++; $display("FAIL bp_rtr_drop got=%b exp=0", rtr_o); end
      end
      acc = rtr_o;
      tick();
      if (acc) idx++;
    end
    rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; res_if.rtr = 1'b1;
    checks++; if (idx != 6) begin failures++; $display("FAIL bp_sent got=%0d exp=6", idx); end
    wait_q(6);
    checks++; if (outq.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", outq.size()); end
    for (int i = 0; i < 6 && i < outq.size(); i++) begin
      checks++; if (outq[i] !== ex[i]) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, outq[i], ex[i]); end
    end
  endtask

  task automatic test_framing();
    send_word(8'h40, 1'b1, 1'b0);
    send_word(8'h40, 1'b0, 1'b0);
    checks++; if (win_cnt_o !== 16'd2 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL frame_mid cnt=%0d err=%b exp=2/0", win_cnt_o, proto_err_o); end
    send_word(8'h40, 1'b1, 1'b0);
    checks++; if (win_cnt_o !== 16'd1 || proto_err_o !== 1'b1) begin
      failures++; $display("FAIL frame_resow cnt=%0d err=%b exp=1/1", win_cnt_o, proto_err_o); end
    send_word(8'h40, 1'b0, 1'b1);
    checks++; if (win_cnt_o !== 16'd2) begin failures++; $display("FAIL frame_eow cnt=%0d exp=2", win_cnt_o); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    send_word(8'h40, 1'b1, 1'b1);
    checks++; if (win_cnt_o !== 16'd1 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL frame_single cnt=%0d err=%b exp=1/0", win_cnt_o, proto_err_o); end
    send_word(8'h40, 1'b0, 1'b0);
    checks++; if (win_cnt_o !== 16'd1 || proto_err_o !== 1'b1) begin
      failures++; $display("FAIL frame_idle_nosow cnt=%0d err=%b exp=1/1", win_cnt_o, proto_err_o); end
    wait_q(0);
  endtask

  task automatic test_reset_in_flight();
    logic [13:0] ex0, ex1;
    ex0 = mk(1, 0, 0, 0, 0, 4'd1, 5'b00000);
    ex1 = mk(0, 1, 0, 0, 0, 4'hA, 5'b00000);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    rts_i = 1'b1; data_i = 8'h40; sow_i = 1'b1; eow_i = 1'b0;
    tick();
    data_i = 8'h50; sow_i = 1'b0;
    tick();
    rst_n = 1'b0; rts_i = 1'b0;
    tick();
    checks++; if (res_if.rts !== 1'b0 || rtr_o !== 1'b0) begin
      failures++; $display("FAIL flight_rst rts=%b rtr=%b exp=0/0", res_if.rts, rtr_o); end
    checks++; if (win_cnt_o !== 16'd0 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL flight_rst_frame cnt=%0d err=%b exp=0/0", win_cnt_o, proto_err_o); end
    rst_n = 1'b1;
    tick();
    outq.delete();
    send_word(8'h60, 1'b1, 1'b0);
    send_word(8'h01, 1'b0, 1'b1);
    wait_q(2);
    checks++; if (outq.size() != 2) begin failures++; $display("FAIL flight_count got=%0d exp=2", outq.size()); end
    if (outq.size() >= 2) begin
      checks++; if (outq[0] !== ex0) begin failures++; $display("FAIL flight_word0 got=%h exp=%h", outq[0], ex0); end
      checks++; if (outq[1] !== ex1) begin failures++; $display("FAIL flight_word1 got=%h exp=%h", outq[1], ex1); end
    end
    checks++; if (win_cnt_o !== 16'd2 || proto_err_o !== 1'b0) begin
      failures++; $display("FAIL flight_frame cnt=%0d err=%b exp=2/0", win_cnt_o, proto_err_o); end
  endtask

  initial begin
    res_if.rtr = 1'b1;
    test_reset();
    test_single_word();
    test_decode_stream();
    test_sign_special();
    test_back_to_back();
    test_framing();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
